// File: rtl/led_mode_sequencer.sv
// LED bank sequencer: switch passthrough, chase, binary count and fill modes stepped by a debounced KEY.
// Optional macro LED_SEQ_PAUSE_EN adds a PAUSE input that freezes the pattern generators.
module led_mode_sequencer #(
  parameter int WIDTH           = 4,
  parameter int TICK_CYCLES     = 25000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [WIDTH-1:0] SW,
  input  logic             KEY,
`ifdef LED_SEQ_PAUSE_EN
  input  logic             PAUSE,
`endif
  output logic [WIDTH-1:0] LEDR,
  output logic [1:0]       MODE
);

  localparam int TW = ($clog2(TICK_CYCLES) > 0) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_CHASE = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_FILL  = 2'd3
  } mode_t;

  logic [WIDTH-1:0] sw_meta, sw_sync;
  logic             key_meta, key_sync;
  logic             key_db;
  logic [DW-1:0]    db_cnt;
  logic             press;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic             hold;
  logic [WIDTH-1:0] pattern, pattern_step, pattern_init;
  mode_t            state, state_next;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      sw_meta  <= SW;
      sw_sync  <= sw_meta;
      key_meta <= KEY;
      key_sync <= key_meta;
    end
  end

`ifdef LED_SEQ_PAUSE_EN
  logic pause_meta, pause_sync;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      pause_meta <= 1'b0;
      pause_sync <= 1'b0;
    end else begin
      pause_meta <= PAUSE;
      pause_sync <= pause_meta;
    end
  end

  assign hold = pause_sync;
`else
  assign hold = 1'b0;
`endif

  // The debounced key only follows the synchronized key after DEBOUNCE_CYCLES of disagreement.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_db <= 1'b1;
      db_cnt <= '0;
    end else if (key_sync != key_db) begin
      if (db_cnt == DB_LAST) begin
        key_db <= key_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Pulses in the cycle the debounced key is about to fall, so the mode moves on the same edge.
  assign press = key_db && !key_sync && (db_cnt == DB_LAST);
  assign tick  = (tick_cnt == TICK_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= MODE_PASS;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (press) begin
      case (state)
        MODE_PASS:  state_next = MODE_CHASE;
        MODE_CHASE: state_next = MODE_COUNT;
        MODE_COUNT: state_next = MODE_FILL;
        default:    state_next = MODE_PASS;
      endcase
    end
  end

  always_comb begin
    MODE = state;
  end

  always_comb begin
    pattern_step = pattern;
    case (state)
      MODE_CHASE: pattern_step = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
      MODE_COUNT: pattern_step = pattern + 1'b1;
      MODE_FILL:  pattern_step = (&pattern) ? '0 : {pattern[WIDTH-2:0], 1'b1};
      default:    pattern_step = pattern;
    endcase
  end

  always_comb begin
    pattern_init = '0;
    if (state_next == MODE_CHASE) begin
      pattern_init = WIDTH'(1);
    end
  end

  // A press takes priority over a coincident tick: the new mode restarts from its initial pattern.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      tick_cnt <= '0;
      pattern  <= '0;
    end else if (press) begin
      tick_cnt <= '0;
      pattern  <= pattern_init;
    end else if (!hold) begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        pattern <= pattern_step;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      LEDR <= '0;
    end else if (state == MODE_PASS) begin
      LEDR <= sw_sync;
    end else begin
      LEDR <= pattern;
    end
  end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with WIDTH=4, TICK_CYCLES=4, DEBOUNCE_CYCLES=3.
// Define LED_SEQ_PAUSE_EN to also exercise the PAUSE freeze.
module tb_led_mode_sequencer;

  typedef struct {
    logic [3:0] sw;
    logic       key;
    int         cycles;
    bit         chk_led;
    logic [3:0] led;
    bit         chk_mode;
    logic [1:0] mode;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       key;
  logic [3:0] ledr;
  logic [1:0] mode;
`ifdef LED_SEQ_PAUSE_EN
  logic       pause;
`endif

  int tests    = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  led_mode_sequencer #(
    .WIDTH(4),
    .TICK_CYCLES(4),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .CLOCK_50(clk),
    .RESET(rst),
    .SW(sw),
    .KEY(key),
`ifdef LED_SEQ_PAUSE_EN
    .PAUSE(pause),
`endif
    .LEDR(ledr),
    .MODE(mode)
  );

  task automatic addVec(input logic [3:0] s, input logic k, input int n,
                        input bit cl, input logic [3:0] l, input bit cm, input logic [1:0] m);
    vec_t v;
    v.sw = s; v.key = k; v.cycles = n;
    v.chk_led = cl; v.led = l; v.chk_mode = cm; v.mode = m;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    sw  = v.sw;
    key = v.key;
    repeat (v.cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input bit chk_led, input logic [3:0] exp_led,
                             input bit chk_mode, input logic [1:0] exp_mode);
    if (chk_led) begin
      tests++;
      if (ledr !== exp_led) begin
        failures++;
        $display("[TB] FAIL %s: LEDR got %b expected %b", name, ledr, exp_led);
      end
    end
    if (chk_mode) begin
      tests++;
      if (mode !== exp_mode) begin
        failures++;
        $display("[TB] FAIL %s: MODE got %0d expected %0d", name, mode, exp_mode);
      end
    end
  endtask

  initial begin
    logic [3:0] sw_vals [5];
    logic [3:0] prev;

    sw_vals = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    prev = 4'b0000;
    // Passthrough: still the old value 2 clocks after a change, the new one at 3.
    for (int i = 0; i < 5; i++) begin
      addVec(sw_vals[i], 1'b1, 2, 1, prev,       1, 2'd0);
      addVec(sw_vals[i], 1'b1, 1, 1, sw_vals[i], 1, 2'd0);
      addVec(sw_vals[i], 1'b1, 2, 0, 4'b0000,    1, 2'd0);
      prev = sw_vals[i];
    end
    // Two-cycle glitch is rejected.
    addVec(4'b1111, 1'b0, 2,  0, 4'b0000, 0, 2'd0);
    addVec(4'b1111, 1'b1, 10, 1, 4'b1111, 1, 2'd0);
    // Long press: mode moves 5 clocks after KEY falls, then the chase sequence.
    addVec(4'b1111, 1'b0, 4, 1, 4'b1111, 1, 2'd0);
    addVec(4'b1111, 1'b0, 1, 1, 4'b1111, 1, 2'd1);
    addVec(4'b1111, 1'b0, 1, 1, 4'b0001, 1, 2'd1);
    addVec(4'b1111, 1'b0, 3, 1, 4'b0001, 1, 2'd1);
    addVec(4'b1111, 1'b0, 1, 1, 4'b0010, 1, 2'd1);
    addVec(4'b1111, 1'b1, 4, 1, 4'b0100, 1, 2'd1);
    addVec(4'b1111, 1'b1, 4, 1, 4'b1000, 1, 2'd1);
    addVec(4'b1111, 1'b1, 4, 1, 4'b0001, 1, 2'd1);
    // Press into COUNT.
    addVec(4'b1111, 1'b0, 5, 0, 4'b0000, 1, 2'd2);
    addVec(4'b1111, 1'b1, 1, 1, 4'b0000, 1, 2'd2);
    addVec(4'b1111, 1'b1, 4, 1, 4'b0001, 1, 2'd2);
    // Press into FILL and walk the full fill sequence.
    addVec(4'b1111, 1'b0, 5, 0, 4'b0000, 1, 2'd3);
    addVec(4'b1111, 1'b1, 1, 1, 4'b0000, 1, 2'd3);
    addVec(4'b1111, 1'b1, 4, 1, 4'b0001, 1, 2'd3);
    addVec(4'b1111, 1'b1, 4, 1, 4'b0011, 1, 2'd3);
    addVec(4'b1111, 1'b1, 4, 1, 4'b0111, 1, 2'd3);
    addVec(4'b1111, 1'b1, 4, 1, 4'b1111, 1, 2'd3);
    addVec(4'b1111, 1'b1, 4, 1, 4'b0000, 1, 2'd3);
    // Back to PASS with a new switch value, then CHASE.
    addVec(4'b0101, 1'b0, 5, 0, 4'b0000, 1, 2'd0);
    addVec(4'b0101, 1'b1, 1, 1, 4'b0101, 1, 2'd0);
    addVec(4'b0101, 1'b1, 4, 0, 4'b0000, 1, 2'd0);
    addVec(4'b0101, 1'b0, 5, 0, 4'b0000, 1, 2'd1);
    addVec(4'b0101, 1'b1, 1, 1, 4'b0001, 1, 2'd1);
    addVec(4'b0101, 1'b1, 4, 1, 4'b0010, 1, 2'd1);
    addVec(4'b0101, 1'b1, 2, 1, 4'b0010, 1, 2'd1);
    // Press lands in the tick cycle: COUNT starts at 0 and steps 4 clocks later.
    addVec(4'b0101, 1'b0, 4, 1, 4'b0100, 1, 2'd1);
    addVec(4'b0101, 1'b0, 1, 1, 4'b0100, 1, 2'd2);
    addVec(4'b0101, 1'b1, 1, 1, 4'b0000, 1, 2'd2);
    addVec(4'b0101, 1'b1, 3, 1, 4'b0000, 1, 2'd2);
    addVec(4'b0101, 1'b1, 1, 1, 4'b0001, 1, 2'd2);
    addVec(4'b0101, 1'b1, 4, 1, 4'b0010, 1, 2'd2);
    addVec(4'b0101, 1'b1, 24, 1, 4'b1000, 1, 2'd2);
    addVec(4'b0101, 1'b1, 28, 1, 4'b1111, 1, 2'd2);
    addVec(4'b0101, 1'b1, 4, 1, 4'b0000, 1, 2'd2);
    // Into FILL up to 0111 ahead of the reset sequence.
    addVec(4'b0101, 1'b0, 5, 0, 4'b0000, 1, 2'd3);
    addVec(4'b0101, 1'b1, 1, 1, 4'b0000, 1, 2'd3);
    addVec(4'b0101, 1'b1, 12, 1, 4'b0111, 1, 2'd3);

    rst = 1'b1;
    key = 1'b1;
    sw  = 4'b0000;
`ifdef LED_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset", 1, 4'b0000, 1, 2'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].chk_led, vecs[i].led,
                  vecs[i].chk_mode, vecs[i].mode);
    end

    // Reset mid-FILL with KEY held low; the press must re-qualify from scratch.
    rst = 1'b1;
    key = 1'b0;
    @(negedge clk);
    checkOutput("reset_mid_fill", 1, 4'b0000, 1, 2'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("requalify_early", 0, 4'b0000, 1, 2'd0);
    @(negedge clk);
    checkOutput("requalify_done", 1, 4'b0101, 1, 2'd1);
    @(negedge clk);
    checkOutput("chase_restart", 1, 4'b0001, 1, 2'd1);
    key = 1'b1;

`ifdef LED_SEQ_PAUSE_EN
    repeat (7) @(negedge clk);
    checkOutput("pre_pause", 1, 4'b0010, 1, 2'd1);
    pause = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("pause_freeze", 1, 4'b0100, 1, 2'd1);
    repeat (12) @(negedge clk);
    checkOutput("pause_hold", 1, 4'b0100, 1, 2'd1);
    pause = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pause_release_wait", 1, 4'b0100, 1, 2'd1);
    @(negedge clk);
    checkOutput("pause_resume", 1, 4'b1000, 1, 2'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
